// File: rtl/trivium_ctrl_if.sv
// Byte-wide handshake bundle for trivium_ctrl: key/IV configuration stream in,
// keystream byte stream out.
interface trivium_ctrl_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] ks_data;
    logic       ks_valid;
    logic       ks_ready;

    modport master (
        output cfg_data, cfg_valid, ks_ready,
        input  cfg_ready, ks_data, ks_valid
    );

    modport slave (
        input  cfg_data, cfg_valid, ks_ready,
        output cfg_ready, ks_data, ks_valid
    );
endinterface

// File: rtl/trivium_ctrl.sv
// Sequencer for the trivium keystream core: byte-serial key/IV load, core load,
// 1152-round warm-up, then packing of core keystream bits into a valid/ready byte stream.
module trivium_ctrl #(
    parameter int KEY_BYTES     = 10,
    parameter int IV_BYTES      = 10,
    parameter int WARMUP_CYCLES = 1152,
    parameter int CNT_W         = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trivium_ctrl_if.slave          bus,
    input  logic                   start,
    input  logic                   stop,
    output logic                   core_load,
    output logic [8*KEY_BYTES-1:0] core_key,
    output logic [8*IV_BYTES-1:0]  core_iv,
    output logic                   core_step,
    input  logic                   core_ks,
    output logic                   busy
);

    localparam int CFG_BYTES = KEY_BYTES + IV_BYTES;
    localparam int BC_W      = $clog2(CFG_BYTES);

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_INIT,
        S_WARMUP,
        S_GEN
    } state_t;

    state_t            state;
    logic [BC_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]  warm_cnt;
    logic [2:0]        bit_cnt;
    logic [6:0]        collect;
    logic              cfg_xfer;
    logic              stall;

    assign cfg_xfer = bus.cfg_valid & bus.cfg_ready;

    // The last bit of a byte may only be taken once the previous byte has left.
    assign stall     = (bit_cnt == 3'd7) && bus.ks_valid && !bus.ks_ready;
    assign core_step = (state == S_WARMUP) || ((state == S_GEN) && !stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_LOAD;
            byte_cnt      <= '0;
            warm_cnt      <= '0;
            bit_cnt       <= 3'd0;
            collect       <= 7'd0;
            core_key      <= '0;
            core_iv       <= '0;
            core_load     <= 1'b0;
            busy          <= 1'b0;
            bus.cfg_ready <= 1'b1;
            bus.ks_data   <= 8'd0;
            bus.ks_valid  <= 1'b0;
        end else begin
            core_load <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (cfg_xfer) begin
                        for (int k = 0; k < KEY_BYTES; k++)
                            if (byte_cnt == BC_W'(k))
                                core_key[8*k +: 8] <= bus.cfg_data;
                        for (int k = 0; k < IV_BYTES; k++)
                            if (byte_cnt == BC_W'(KEY_BYTES + k))
                                core_iv[8*k +: 8] <= bus.cfg_data;
                        if (byte_cnt == BC_W'(CFG_BYTES - 1)) begin
                            byte_cnt <= '0;
                            state    <= S_READY;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end

                // A new cfg byte starts a rekey and takes priority over start.
                S_READY: begin
                    if (cfg_xfer) begin
                        core_key[7:0] <= bus.cfg_data;
                        byte_cnt      <= BC_W'(1);
                        state         <= S_LOAD;
                    end else if (start) begin
                        state         <= S_INIT;
                        core_load     <= 1'b1;
                        busy          <= 1'b1;
                        bus.cfg_ready <= 1'b0;
                    end
                end

                S_INIT: begin
                    if (stop) begin
                        state         <= S_READY;
                        busy          <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                    end else begin
                        warm_cnt <= '0;
                        state    <= S_WARMUP;
                    end
                end

                S_WARMUP: begin
                    if (stop) begin
                        state         <= S_READY;
                        busy          <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                    end else if (warm_cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
                        bit_cnt <= 3'd0;
                        state   <= S_GEN;
                    end else begin
                        warm_cnt <= warm_cnt + CNT_W'(1);
                    end
                end

                // Bits enter at the top of collect so the first bit ends up in ks_data[0].
                S_GEN: begin
                    if (stop) begin
                        state         <= S_READY;
                        busy          <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                        bus.ks_valid  <= 1'b0;
                        bit_cnt       <= 3'd0;
                    end else begin
                        if (core_step) begin
                            collect <= {core_ks, collect[6:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (core_step && (bit_cnt == 3'd7)) begin
                            bus.ks_data  <= {core_ks, collect};
                            bus.ks_valid <= 1'b1;
                        end else if (bus.ks_valid && bus.ks_ready) begin
                            bus.ks_valid <= 1'b0;
                        end
                    end
                end

                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Bench for trivium_ctrl: drives a behavioural trivium core and checks the byte
// stream against a keystream produced by a reference trivium model.
module tb_trivium_ctrl;

    localparam int WARM = 1152;
    localparam int NB   = 48;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        core_load;
    logic        core_step;
    logic        core_ks;
    logic        busy;
    logic [79:0] core_key;
    logic [79:0] core_iv;

    trivium_ctrl_if bus ();

    trivium_ctrl #(
        .KEY_BYTES    (10),
        .IV_BYTES     (10),
        .WARMUP_CYCLES(WARM),
        .CNT_W        (11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .start    (start),
        .stop     (stop),
        .core_load(core_load),
        .core_key (core_key),
        .core_iv  (core_iv),
        .core_step(core_step),
        .core_ks  (core_ks),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [79:0] tb_key = '0;
    logic [79:0] tb_iv  = '0;
    int          ld_cnt = 0;
    bit          in_ready = 1'b0;
    bit          pattern_mode = 1'b0;
    logic [7:0]  pat = 8'h8D;
    logic [287:0] st = '0;
    int          step_cnt = 0;
    logic [7:0]  exp_bytes [NB];
    int          n_rx = 0;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;

    // Trivium state: st[i-1] holds s_i of the published description.
    function automatic logic triv_z(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [287:0] triv_next(input logic [287:0] s);
        logic t1, t2, t3;
        logic [287:0] r;
        t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        r[92:0]    = {s[91:0], t3};
        r[176:93]  = {s[175:93], t1};
        r[287:177] = {s[286:177], t2};
        return r;
    endfunction

    function automatic logic [287:0] triv_load(input logic [79:0] k, input logic [79:0] v);
        logic [287:0] r;
        r          = '0;
        r[79:0]    = k;
        r[172:93]  = v;
        r[287:285] = 3'b111;
        return r;
    endfunction

    // Stand-in for the keystream core datapath.
    always @(posedge clk) begin
        if (core_load) begin
            st       <= triv_load(core_key, core_iv);
            step_cnt <= 0;
        end else if (core_step) begin
            st       <= triv_next(st);
            step_cnt <= step_cnt + 1;
        end
    end

    assign core_ks = pattern_mode ? pat[step_cnt % 8] : triv_z(st);

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Bytes the stream must carry: skip WARM keystream bits, then pack 8 per byte, first bit in [0].
    task automatic build_expected(input logic [79:0] k, input logic [79:0] v);
        logic [287:0] s;
        logic [7:0]   b;
        s = triv_load(k, v);
        for (int i = 0; i < WARM; i++) s = triv_next(s);
        for (int n = 0; n < NB; n++) begin
            for (int j = 0; j < 8; j++) begin
                if (pattern_mode) b[j] = pat[(WARM + 8*n + j) % 8];
                else              b[j] = triv_z(s);
                s = triv_next(s);
            end
            exp_bytes[n] = b;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            n_rx      = 0;
            prev_hold = 1'b0;
        end else begin
            if (core_load) begin
                checkOutput("core_key_at_load", core_key, tb_key);
                checkOutput("core_iv_at_load", core_iv, tb_iv);
                build_expected(tb_key, tb_iv);
                n_rx = 0;
            end
            if (bus.ks_valid && prev_hold)
                checkOutput("ks_data_stable", {72'd0, bus.ks_data}, {72'd0, prev_data});
            if (bus.ks_valid && bus.ks_ready) begin
                if (n_rx < NB) checkOutput($sformatf("ks_byte_%0d", n_rx), {72'd0, bus.ks_data}, {72'd0, exp_bytes[n_rx]});
                n_rx++;
            end
            prev_hold = bus.ks_valid && !bus.ks_ready;
            prev_data = bus.ks_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        bus.cfg_data  = d;
        bus.cfg_valid = 1'b1;
        checkOutput("cfg_ready_on_send", {79'd0, bus.cfg_ready}, 80'd1);
        tick();
        bus.cfg_valid = 1'b0;
        if (in_ready) begin
            tb_key[7:0] = d;
            ld_cnt      = 1;
            in_ready    = 1'b0;
        end else begin
            if (ld_cnt < 10) tb_key[8*ld_cnt +: 8] = d;
            else             tb_iv[8*(ld_cnt-10) +: 8] = d;
            ld_cnt++;
            if (ld_cnt == 20) begin
                ld_cnt   = 0;
                in_ready = 1'b1;
            end
        end
    endtask

    // Cycle 0 is the READY cycle in which start is sampled; INIT is cycle 1.
    task automatic run_to_first_byte();
        int cyc, steps, loads;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("init_core_load", {79'd0, core_load}, 80'd1);
        checkOutput("init_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("init_busy", {79'd0, busy}, 80'd1);
        checkOutput("init_cfg_ready", {79'd0, bus.cfg_ready}, 80'd0);
        cyc = 1; steps = 0; loads = 0;
        while (!bus.ks_valid && cyc < 1400) begin
            tick();
            cyc++;
            if (core_load) loads++;
            if (!bus.ks_valid && core_step) steps++;
        end
        checkOutput("first_ks_valid_cycle", 80'(cyc), 80'd1162);
        checkOutput("steps_before_first_byte", 80'(steps), 80'(WARM + 8));
        checkOutput("extra_core_load", 80'(loads), 80'd0);
    endtask

    task automatic next_byte(output int gap, output logic [7:0] d);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!bus.ks_valid && gap < 40);
        d = bus.ks_data;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         gap, steps;
        logic [7:0] d, held;

        bus.cfg_data  = 8'd0;
        bus.cfg_valid = 1'b0;
        bus.ks_ready  = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_cfg_ready", {79'd0, bus.cfg_ready}, 80'd1);
        checkOutput("rst_busy", {79'd0, busy}, 80'd0);
        checkOutput("rst_ks_valid", {79'd0, bus.ks_valid}, 80'd0);
        checkOutput("rst_ks_data", {72'd0, bus.ks_data}, 80'd0);
        checkOutput("rst_core_load", {79'd0, core_load}, 80'd0);
        checkOutput("rst_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("rst_core_key", core_key, 80'd0);
        checkOutput("rst_core_iv", core_iv, 80'd0);
        #21 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                checkOutput("start_ignored_in_load", {79'd0, busy}, 80'd0);
            end
            applyStimulus(8'(i));
        end
        checkOutput("load_core_key", core_key, 80'h09080706050403020100);
        checkOutput("load_core_iv", core_iv, 80'h13121110_0F0E0D0C0B0A);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_ignored_in_ready", {79'd0, busy}, 80'd0);

        pattern_mode = 1'b1;
        run_to_first_byte();
        checkOutput("pattern_first_byte", {72'd0, bus.ks_data}, 80'h8D);
        next_byte(gap, d);
        checkOutput("pattern_gap", 80'(gap), 80'd8);
        checkOutput("pattern_second_byte", {72'd0, d}, 80'h8D);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_gen_ks_valid", {79'd0, bus.ks_valid}, 80'd0);
        checkOutput("stop_gen_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("stop_gen_busy", {79'd0, busy}, 80'd0);

        applyStimulus(8'hA5);
        checkOutput("rekey_byte0", {72'd0, core_key[7:0]}, 80'hA5);
        applyStimulus(8'h5A);
        checkOutput("rekey_byte1", {72'd0, core_key[15:8]}, 80'h5A);
        checkOutput("rekey_rest_kept", {16'd0, core_key[79:16]}, 80'h0908070605040302);
        for (int i = 0; i < 18; i++) applyStimulus(8'h00);
        for (int i = 0; i < 20; i++) applyStimulus(8'h00);
        checkOutput("zero_core_key", core_key, 80'd0);
        checkOutput("zero_core_iv", core_iv, 80'd0);

        pattern_mode = 1'b0;
        run_to_first_byte();
        for (int i = 0; i < 5; i++) begin
            next_byte(gap, d);
            checkOutput("stream_gap", 80'(gap), 80'd8);
        end

        held = bus.ks_data;
        bus.ks_ready = 1'b0;
        steps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_step) steps++;
        end
        checkOutput("stall_steps", 80'(steps), 80'd6);
        checkOutput("stall_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("stall_ks_valid", {79'd0, bus.ks_valid}, 80'd1);
        checkOutput("stall_ks_data", {72'd0, bus.ks_data}, {72'd0, held});
        bus.ks_ready = 1'b1;
        next_byte(gap, d);
        checkOutput("release_gap", 80'(gap), 80'd1);
        for (int i = 0; i < 3; i++) begin
            next_byte(gap, d);
            checkOutput("post_stall_gap", 80'(gap), 80'd8);
        end

        held = bus.ks_data;
        repeat (7) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("stop_vs_load_valid", {79'd0, bus.ks_valid}, 80'd0);
        checkOutput("stop_vs_load_data", {72'd0, bus.ks_data}, {72'd0, held});

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        checkOutput("warmup_core_step", {79'd0, core_step}, 80'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("abort_busy", {79'd0, busy}, 80'd0);
        checkOutput("abort_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("abort_cfg_ready", {79'd0, bus.cfg_ready}, 80'd1);
        tick();
        checkOutput("abort_idle_step", {79'd0, core_step}, 80'd0);
        run_to_first_byte();
        next_byte(gap, d);
        checkOutput("restart_gap", 80'(gap), 80'd8);

        repeat (3) tick();
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midgen_rst_ks_valid", {79'd0, bus.ks_valid}, 80'd0);
        checkOutput("midgen_rst_core_step", {79'd0, core_step}, 80'd0);
        checkOutput("midgen_rst_cfg_ready", {79'd0, bus.cfg_ready}, 80'd1);
        checkOutput("midgen_rst_busy", {79'd0, busy}, 80'd0);
        checkOutput("midgen_rst_core_key", core_key, 80'd0);
        tb_key = '0; tb_iv = '0; ld_cnt = 0; in_ready = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("post_rst_start_ignored", {79'd0, busy}, 80'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
